// File: rtl/control.sv
// Main-decoder control unit: turns the 6-bit opcode into datapath control bits.
// The decode is combinational, and the result is registered, so it appears one clock after op.
module control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrc,
   output logic       MemWrite,
   output logic       MemRead,
   output logic       MemtoReg,
   output logic       Branch,
   output logic [1:0] ALUctr
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   typedef struct packed {
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       branch;
      logic [1:0] alu_ctr;
   } ctrl_t;

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   // Any opcode that matches no item, including one carrying X/Z bits, falls to the NOP default.
   always_comb begin
      ctrl_d = '0;
      case (op)
         OP_RTYPE: ctrl_d = '{reg_dst: 1'b1, reg_write: 1'b1, alu_src: 1'b0, mem_write: 1'b0,
                              mem_read: 1'b0, mem_to_reg: 1'b0, branch: 1'b0, alu_ctr: 2'b10};
         OP_LW:    ctrl_d = '{reg_dst: 1'b0, reg_write: 1'b1, alu_src: 1'b1, mem_write: 1'b0,
                              mem_read: 1'b1, mem_to_reg: 1'b1, branch: 1'b0, alu_ctr: 2'b00};
         OP_SW:    ctrl_d = '{reg_dst: 1'b0, reg_write: 1'b0, alu_src: 1'b1, mem_write: 1'b1,
                              mem_read: 1'b0, mem_to_reg: 1'b0, branch: 1'b0, alu_ctr: 2'b00};
         OP_BEQ:   ctrl_d = '{reg_dst: 1'b0, reg_write: 1'b0, alu_src: 1'b0, mem_write: 1'b0,
                              mem_read: 1'b0, mem_to_reg: 1'b0, branch: 1'b1, alu_ctr: 2'b01};
         OP_ADDI:  ctrl_d = '{reg_dst: 1'b0, reg_write: 1'b1, alu_src: 1'b1, mem_write: 1'b0,
                              mem_read: 1'b0, mem_to_reg: 1'b0, branch: 1'b0, alu_ctr: 2'b00};
         OP_LUI:   ctrl_d = '{reg_dst: 1'b0, reg_write: 1'b1, alu_src: 1'b1, mem_write: 1'b0,
                              mem_read: 1'b0, mem_to_reg: 1'b0, branch: 1'b0, alu_ctr: 2'b11};
         default:  ctrl_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign RegDst   = ctrl_q.reg_dst;
   assign RegWrite = ctrl_q.reg_write;
   assign ALUSrc   = ctrl_q.alu_src;
   assign MemWrite = ctrl_q.mem_write;
   assign MemRead  = ctrl_q.mem_read;
   assign MemtoReg = ctrl_q.mem_to_reg;
   assign Branch   = ctrl_q.branch;
   assign ALUctr   = ctrl_q.alu_ctr;

endmodule

// File: tb/tb_control.sv
// Bench for the control decoder: directed table, multi-cycle reset/latency sequences,
// and random opcodes scored against a lookup-table model of the instruction set.
`timescale 1ns/100ps
module tb_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic       RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch;
   logic [1:0] ALUctr;
   logic [8:0] outs;

   int checks   = 0;
   int failures = 0;

   logic [8:0] exp_q[$];

   control dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (op),
      .RegDst   (RegDst),
      .RegWrite (RegWrite),
      .ALUSrc   (ALUSrc),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .MemtoReg (MemtoReg),
      .Branch   (Branch),
      .ALUctr   (ALUctr)
   );

   assign outs = {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch, ALUctr};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction-set reference: opcode -> control row, written as the ISA table
   typedef struct {
      logic [5:0] opc;
      logic [8:0] row;
   } isa_t;
   isa_t isa[6];

   function automatic logic [8:0] model(input logic [5:0] o);
      logic [8:0] r;
      r = 9'b0;
      for (int k = 0; k < 6; k++)
         if (isa[k].opc === o) r = isa[k].row;
      return r;
   endfunction

   localparam logic [8:0] ROW_R   = 9'b1_1_0_0_0_0_0_10;
   localparam logic [8:0] ROW_LW  = 9'b0_1_1_0_1_1_0_00;
   localparam logic [8:0] ROW_SW  = 9'b0_0_1_1_0_0_0_00;
   localparam logic [8:0] ROW_BEQ = 9'b0_0_0_0_0_0_1_01;
   localparam logic [8:0] ROW_ADI = 9'b0_1_1_0_0_0_0_00;
   localparam logic [8:0] ROW_LUI = 9'b0_1_1_0_0_0_0_11;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b (op=%b)", name, act, exp, op);
      end
   endtask

   // driver: apply op after the falling edge, check just after the next rising edge
   task automatic drive_and_check(input string name, input logic [5:0] o, input logic [8:0] exp);
      @(negedge clk);
      op = o;
      @(posedge clk);
      #1;
      check(name, outs, exp);
   endtask

   // store and register write must never coincide
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (MemWrite && RegWrite) begin
            failures++;
            $display("FAIL invariant_mw_rw: MemWrite=%b RegWrite=%b expected not both 1", MemWrite, RegWrite);
         end
      end
   end

   typedef struct {
      logic [5:0] op;
      logic [8:0] exp;
   } vec_t;
   vec_t vecs[10];

   initial begin
      logic [5:0] o;
      logic [8:0] e;

      isa[0] = '{6'b000000, ROW_R};
      isa[1] = '{6'b100011, ROW_LW};
      isa[2] = '{6'b101011, ROW_SW};
      isa[3] = '{6'b000100, ROW_BEQ};
      isa[4] = '{6'b001000, ROW_ADI};
      isa[5] = '{6'b001111, ROW_LUI};

      vecs[0] = '{6'b000000, ROW_R};
      vecs[1] = '{6'b100011, ROW_LW};
      vecs[2] = '{6'b101011, ROW_SW};
      vecs[3] = '{6'b000100, ROW_BEQ};
      vecs[4] = '{6'b001000, ROW_ADI};
      vecs[5] = '{6'b001111, ROW_LUI};
      vecs[6] = '{6'b111111, 9'b0};
      vecs[7] = '{6'b000010, 9'b0};
      vecs[8] = '{6'b100000, 9'b0};
      vecs[9] = '{6'b001001, 9'b0};

      // reset held with R-type on op and the clock running
      rst_n = 1'b0;
      op    = 6'b000000;
      repeat (3) @(posedge clk);
      #1 check("reset_hold", outs, 9'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("reset_release_rtype", outs, ROW_R);

      // directed decode table
      foreach (vecs[i]) drive_and_check($sformatf("table_%0d", i), vecs[i].op, vecs[i].exp);

      // opcode stepped every 100 ns: new row one edge after the change, held for the rest
      begin
         logic [5:0] seq[5];
         seq[0] = 6'b000000; seq[1] = 6'b100011; seq[2] = 6'b101011;
         seq[3] = 6'b000100; seq[4] = 6'b001111;
         for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            op = seq[s];
            for (int c = 0; c < 10; c++) begin
               @(posedge clk);
               #1 check($sformatf("seq_%0d_cyc%0d", s, c), outs, model(seq[s]));
            end
         end
      end

      // latency: lw -> sw just before an edge
      drive_and_check("lat_lw", 6'b100011, ROW_LW);
      @(posedge clk);
      #4;
      op = 6'b101011;
      #0.5 check("lat_before_edge", outs, ROW_LW);
      @(posedge clk);
      #1 check("lat_after_edge", outs, ROW_SW);

      // unknown opcode after a valid one
      drive_and_check("unknown_111111", 6'b111111, 9'b0);

      // asynchronous reset pulse between edges
      drive_and_check("async_pre_lw", 6'b100011, ROW_LW);
      #2;
      rst_n = 1'b0;
      #1 check("async_reset_no_edge", outs, 9'b0);
      #1 rst_n = 1'b1;
      #1 check("async_release_before_edge", outs, 9'b0);
      @(posedge clk);
      #1 check("async_release_lw", outs, ROW_LW);

      // reset during a pending change: no stale decode after release
      @(negedge clk);
      op = 6'b000100;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 check("reset_overrides_pending", outs, 9'b0);
      @(negedge clk);
      op = 6'b001000;
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("release_loads_current", outs, ROW_ADI);

      // random opcodes, biased toward the legal set
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 1) == 0) o = isa[$urandom_range(0, 5)].opc;
         else o = 6'($urandom_range(0, 63));
         op = o;
         exp_q.push_back(model(o));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("rand_%0d", n), outs, e);
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 Ports SHALL be, one per line, with clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op  input  6  instruction opcode field, bits [31:26].
- RegDst  output  1  register write destination: 1 = rd, 0 = rt.
- RegWrite  output  1  register file write enable.
- ALUSrc  output  1  ALU operand B source: 1 = immediate, 0 = register.
- MemWrite  output  1  data memory write enable.
- MemRead  output  1  data memory read enable.
- MemtoReg  output  1  writeback source: 1 = memory, 0 = ALU.
- Branch  output  1  branch-on-equal qualifier.
- ALUctr  output  2  ALU operation class: 00 add, 01 subtract, 10 funct-decoded (R-type), 11 load-upper-immediate.

Function
REQ-003 All outputs SHALL be registered.
- op is decoded combinationally.
- The decode is captured on every rising clk edge.
- Latency is exactly 1 cycle: a new op applied before edge N appears on the outputs after edge N.
REQ-004 Decode table, listed as RegDst RegWrite ALUSrc MemWrite MemRead MemtoReg Branch ALUctr, SHALL be:
- 000000 R-type: 1 1 0 0 0 0 0 10.
- 100011 lw: 0 1 1 0 1 1 0 00.
- 101011 sw: 0 0 1 1 0 0 0 00.
- 000100 beq: 0 0 0 0 0 0 1 01.
- 001000 addi: 0 1 1 0 0 0 0 00.
- 001111 lui: 0 1 1 0 0 0 0 11.
REQ-005 Any other opcode SHALL decode to all outputs 0 (safe NOP: no register write, no memory access, no branch, ALUctr 00).
REQ-006 MemWrite and RegWrite SHALL never both be 1; MemRead SHALL be 1 only when MemtoReg is 1.
REQ-007 The outputs SHALL hold their value while op is unchanged; there is no handshake or enable.
REQ-008 Decoding SHALL depend only on the current op; no history is kept.
REQ-009 X or Z bits on op SHALL be treated as the unknown-opcode case in simulation, giving the REQ-005 NOP decode.

Reset
REQ-010 rst_n = 0 SHALL immediately force every output to 0, without waiting for clk.
REQ-011 While rst_n = 0, outputs SHALL stay 0 regardless of op or clk.
REQ-012 On rst_n deassertion, the first rising clk edge SHALL load the decode of the op present at that edge.
REQ-013 Reset asserted mid-operation SHALL override any pending decode; no stale value SHALL appear after release.

Verification
REQ-014 The bench SHALL cover these directed scenarios:
- Reset: rst_n = 0 with op = 000000 and clk running -> all outputs 0; release, one edge -> R-type row (1 1 0 0 0 0 0 10).
- Sequence: op stepped 000000, 100011, 101011, 000100, 001111, one opcode per 100 ns with clk period 10 ns -> each REQ-004 row appears one edge after the change and holds until the next change.
- Latency: op changed from 100011 to 101011 just before an edge -> outputs show the lw row until that edge and the sw row after it.
- Unknown opcode: op = 111111 -> all outputs 0 after one edge.
- Asynchronous reset: rst_n pulsed low between edges while op = 100011 -> outputs go to 0 within the pulse with no clk edge; after release and one edge -> lw row.
- Invariant check: every cycle -> never MemWrite and RegWrite both 1.
